// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, RV32I decoder,
// trap merging and the 32x32 integer register file with write-through reads.
module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] instr_i,
   input  logic [31:0] PC_i,
   input  logic [31:0] PC4_i,
   input  logic        is_trap_i,
   input  logic [3:0]  trap_code_i,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        ready_o,
   output logic        valid_id_o,
   output logic [31:0] PC_id_o,
   output logic [31:0] PC4_id_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o,
   output logic [31:0] imm_o,
   output logic [2:0]  funct3_o,
   output logic        funct7b5_o,
   output logic [3:0]  op_class_o,
   output logic        is_trap_id_o,
   output logic [3:0]  trap_code_id_o
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   logic        valid_reg;
   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic [31:0] pc4_reg;
   logic        trap_reg;
   logic [3:0]  trap_code_reg;
   logic [31:0] rf_reg [0:31];

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [3:0]  op_class_next;
   logic [31:0] imm_next;
   logic        illegal;
   logic        is_ecall;
   logic        is_ebreak;
   logic [4:0]  rs_idx  [0:1];
   logic [31:0] rs_data [0:1];

   assign ready_o = ~stall_i;

   // IF/ID register: flush beats stall; an empty fetch loads a NOP bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_reg     <= 1'b0;
         instr_reg     <= NOP_INSTR;
         pc_reg        <= '0;
         pc4_reg       <= '0;
         trap_reg      <= 1'b0;
         trap_code_reg <= '0;
      end else if (flush_i) begin
         valid_reg     <= 1'b0;
         instr_reg     <= NOP_INSTR;
         trap_reg      <= 1'b0;
         trap_code_reg <= '0;
      end else if (!stall_i) begin
         valid_reg <= valid_i;
         pc_reg    <= PC_i;
         pc4_reg   <= PC4_i;
         if (valid_i) begin
            instr_reg     <= instr_i;
            trap_reg      <= is_trap_i;
            trap_code_reg <= trap_code_i;
         end else begin
            instr_reg     <= NOP_INSTR;
            trap_reg      <= 1'b0;
            trap_code_reg <= '0;
         end
      end
   end

   // Register file write port; x0 is never written and stays zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
      end else if (wb_we_i && (wb_rd_i != 5'd0)) begin
         rf_reg[wb_rd_i] <= wb_data_i;
      end
   end

   assign opcode = instr_reg[6:0];
   assign funct3 = instr_reg[14:12];
   assign funct7 = instr_reg[31:25];

   assign rs_idx[0] = instr_reg[19:15];
   assign rs_idx[1] = instr_reg[24:20];

   // Two read ports, each forwarding a same-cycle writeback to its index.
   for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
         rs_data[gi] = rf_reg[rs_idx[gi]];
         if (rs_idx[gi] == 5'd0)
            rs_data[gi] = '0;
         else if (wb_we_i && (wb_rd_i == rs_idx[gi]))
            rs_data[gi] = wb_data_i;
      end
   end

   assign is_ecall  = (instr_reg == ECALL_INSTR);
   assign is_ebreak = (instr_reg == EBREAK_INSTR);

   // Opcode classification, field-level legality checks and immediate format.
   always_comb begin
      op_class_next = 4'd15;
      imm_next      = '0;
      if (instr_reg[1:0] == 2'b11) begin
         case (opcode)
            OPC_LUI: begin
               op_class_next = 4'd0;
               imm_next      = {instr_reg[31:12], 12'b0};
            end
            OPC_AUIPC: begin
               op_class_next = 4'd1;
               imm_next      = {instr_reg[31:12], 12'b0};
            end
            OPC_JAL: begin
               op_class_next = 4'd2;
               imm_next      = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                                instr_reg[20], instr_reg[30:21], 1'b0};
            end
            OPC_JALR: begin
               if (funct3 == 3'd0) op_class_next = 4'd3;
               imm_next = {{20{instr_reg[31]}}, instr_reg[31:20]};
            end
            OPC_BRANCH: begin
               if (funct3 != 3'd2 && funct3 != 3'd3) op_class_next = 4'd4;
               imm_next = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                           instr_reg[30:25], instr_reg[11:8], 1'b0};
            end
            OPC_LOAD: begin
               if (funct3 != 3'd3 && funct3 < 3'd6) op_class_next = 4'd5;
               imm_next = {{20{instr_reg[31]}}, instr_reg[31:20]};
            end
            OPC_STORE: begin
               if (funct3 <= 3'd2) op_class_next = 4'd6;
               imm_next = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
            end
            OPC_OPIMM: begin
               op_class_next = 4'd7;
               if (funct3 == 3'd1 && funct7 != 7'h00)
                  op_class_next = 4'd15;
               if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20)
                  op_class_next = 4'd15;
               imm_next = {{20{instr_reg[31]}}, instr_reg[31:20]};
            end
            OPC_OP: begin
               if (funct7 == 7'h00 ||
                   (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)))
                  op_class_next = 4'd8;
            end
            OPC_FENCE: begin
               op_class_next = 4'd9;
            end
            OPC_SYSTEM: begin
               if (funct3 != 3'd0 || is_ecall || is_ebreak) op_class_next = 4'd10;
            end
            default: op_class_next = 4'd15;
         endcase
      end
   end

   assign illegal = (op_class_next == 4'd15);

   // Trap merge: a fetch trap outranks anything found while decoding.
   always_comb begin
      trap_code_id_o = 4'd0;
      if (trap_reg)       trap_code_id_o = trap_code_reg;
      else if (illegal)   trap_code_id_o = 4'd2;
      else if (is_ecall)  trap_code_id_o = 4'd11;
      else if (is_ebreak) trap_code_id_o = 4'd3;
   end

   assign is_trap_id_o = valid_reg & (trap_reg | illegal | is_ecall | is_ebreak);

   assign valid_id_o = valid_reg;
   assign PC_id_o    = pc_reg;
   assign PC4_id_o   = pc4_reg;
   assign rs1_o      = instr_reg[19:15];
   assign rs2_o      = instr_reg[24:20];
   assign rd_o       = instr_reg[11:7];
   assign rs1_data_o = rs_data[0];
   assign rs2_data_o = rs_data[1];
   assign imm_o      = imm_next;
   assign funct3_o   = funct3;
   assign funct7b5_o = instr_reg[30];
   assign op_class_o = op_class_next;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expectations.
module tb_id_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] instr_i;
   logic [31:0] PC_i;
   logic [31:0] PC4_i;
   logic        is_trap_i;
   logic [3:0]  trap_code_i;
   logic        valid_i;
   logic        stall_i;
   logic        flush_i;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        ready_o;
   logic        valid_id_o;
   logic [31:0] PC_id_o;
   logic [31:0] PC4_id_o;
   logic [4:0]  rs1_o;
   logic [4:0]  rs2_o;
   logic [4:0]  rd_o;
   logic [31:0] rs1_data_o;
   logic [31:0] rs2_data_o;
   logic [31:0] imm_o;
   logic [2:0]  funct3_o;
   logic        funct7b5_o;
   logic [3:0]  op_class_o;
   logic        is_trap_id_o;
   logic [3:0]  trap_code_id_o;

   int checks = 0;
   int errors = 0;

   id_stage dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .instr_i        (instr_i),
      .PC_i           (PC_i),
      .PC4_i          (PC4_i),
      .is_trap_i      (is_trap_i),
      .trap_code_i    (trap_code_i),
      .valid_i        (valid_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .wb_we_i        (wb_we_i),
      .wb_rd_i        (wb_rd_i),
      .wb_data_i      (wb_data_i),
      .ready_o        (ready_o),
      .valid_id_o     (valid_id_o),
      .PC_id_o        (PC_id_o),
      .PC4_id_o       (PC4_id_o),
      .rs1_o          (rs1_o),
      .rs2_o          (rs2_o),
      .rd_o           (rd_o),
      .rs1_data_o     (rs1_data_o),
      .rs2_data_o     (rs2_data_o),
      .imm_o          (imm_o),
      .funct3_o       (funct3_o),
      .funct7b5_o     (funct7b5_o),
      .op_class_o     (op_class_o),
      .is_trap_id_o   (is_trap_id_o),
      .trap_code_id_o (trap_code_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
      instr_i = ins;
      PC_i    = pc;
      PC4_i   = pc + 32'd4;
      valid_i = 1'b1;
   endtask

   initial begin
      rst_ni = 1'b0; instr_i = '0; PC_i = '0; PC4_i = '0;
      is_trap_i = 1'b0; trap_code_i = '0; valid_i = 1'b0;
      stall_i = 1'b0; flush_i = 1'b0;
      wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;

      tick();
      chk("rst_valid", valid_id_o, 0);
      chk("rst_class", op_class_o, 7);
      chk("rst_trap", is_trap_id_o, 0);
      chk("rst_pc", PC_id_o, 0);

      // addi x1,x0,5
      rst_ni = 1'b1;
      fetch(32'h0050_0093, 32'h100);
      chk("ready_idle", ready_o, 1);
      tick();
      $display("addi x1,x0,5 @0x100");
      chk("addi_valid", valid_id_o, 1);
      chk("addi_class", op_class_o, 7);
      chk("addi_imm", imm_o, 5);
      chk("addi_rd", rd_o, 1);
      chk("addi_pc", PC_id_o, 32'h100);
      chk("addi_pc4", PC4_id_o, 32'h104);

      // addi x2,x3,0 : bypass of a same-cycle write to x3
      fetch(32'h0001_8113, 32'h104);
      tick();
      chk("rs1_idx", rs1_o, 3);
      wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEAD_BEEF;
      #1;
      $display("wb x3=deadbeef bypass");
      chk("bypass_rs1", rs1_data_o, 32'hDEAD_BEEF);
      tick();
      wb_we_i = 1'b0;
      #1;
      chk("stored_rs1", rs1_data_o, 32'hDEAD_BEEF);

      // write to x0 is dropped, including on the bypass path
      wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h1234_5678;
      #1;
      $display("wb x0=12345678");
      chk("x0_bypass", rs2_data_o, 0);
      tick();
      wb_we_i = 1'b0;
      #1;
      chk("x0_stored", rs2_data_o, 0);

      // x1 = 5, then read it via addi x2,x1,0
      wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'd5;
      fetch(32'h0000_8113, 32'h110);
      tick();
      wb_we_i = 1'b0;
      #1;
      $display("addi x2,x1,0 @0x110");
      chk("x1_read", rs1_data_o, 5);

      // stall for 3 cycles with changing input
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fetch(32'hFFFF_FFFF - k, 32'h200 + 4 * k);
         #1;
         chk("stall_ready", ready_o, 0);
         tick();
         $display("stall cycle %0d", k);
         chk("stall_pc", PC_id_o, 32'h110);
         chk("stall_class", op_class_o, 7);
         chk("stall_rs1", rs1_o, 1);
      end
      flush_i = 1'b1;
      tick();
      $display("flush during stall");
      chk("flush_valid", valid_id_o, 0);
      chk("flush_trap", is_trap_id_o, 0);
      chk("flush_class", op_class_o, 7);
      stall_i = 1'b0; flush_i = 1'b0;

      // illegal, then the same with a fetch trap
      fetch(32'hFFFF_FFFF, 32'h300);
      tick();
      $display("illegal ffffffff");
      chk("ill_class", op_class_o, 15);
      chk("ill_trap", is_trap_id_o, 1);
      chk("ill_code", trap_code_id_o, 2);
      is_trap_i = 1'b1; trap_code_i = 4'd1;
      tick();
      $display("illegal with IF trap 1");
      chk("iftrap_trap", is_trap_id_o, 1);
      chk("iftrap_code", trap_code_id_o, 1);
      is_trap_i = 1'b0; trap_code_i = 4'd0;

      fetch(32'h0000_0073, 32'h304);
      tick();
      $display("ecall");
      chk("ecall_class", op_class_o, 10);
      chk("ecall_trap", is_trap_id_o, 1);
      chk("ecall_code", trap_code_id_o, 11);

      fetch(32'h0010_0073, 32'h308);
      tick();
      $display("ebreak");
      chk("ebreak_trap", is_trap_id_o, 1);
      chk("ebreak_code", trap_code_id_o, 3);

      // mul x0,x0,x0 (funct7=1) is not RV32I
      fetch(32'h0200_0033, 32'h30C);
      tick();
      $display("op funct7=1");
      chk("op_f7_class", op_class_o, 15);

      fetch(32'h4010_5093, 32'h310);
      tick();
      $display("srai x1,x0,1");
      chk("srai_class", op_class_o, 7);
      chk("srai_f7b5", funct7b5_o, 1);

      fetch(32'h4010_1093, 32'h314);
      tick();
      $display("slli with funct7=0x20");
      chk("slli_class", op_class_o, 15);

      fetch(32'h1234_50B7, 32'h318);
      tick();
      $display("lui x1,0x12345");
      chk("lui_class", op_class_o, 0);
      chk("lui_imm", imm_o, 32'h1234_5000);

      fetch(32'h0020_A423, 32'h31C);
      tick();
      $display("sw x2,8(x1)");
      chk("sw_class", op_class_o, 6);
      chk("sw_imm", imm_o, 8);
      chk("sw_f3", funct3_o, 2);

      fetch(32'hFE00_0EE3, 32'h320);
      tick();
      $display("beq x0,x0,-4");
      chk("beq_class", op_class_o, 4);
      chk("beq_imm", imm_o, 32'hFFFF_FFFC);
      chk("beq_trap", is_trap_id_o, 0);

      // asynchronous reset between edges
      #3;
      rst_ni = 1'b0;
      #1;
      $display("async reset asserted");
      chk("arst_valid", valid_id_o, 0);
      chk("arst_pc", PC_id_o, 0);
      #1;
      rst_ni = 1'b1;
      fetch(32'h0000_8113, 32'h400);
      tick();
      $display("addi x2,x1,0 after reset");
      chk("arst_valid2", valid_id_o, 1);
      chk("arst_x1", rs1_data_o, 0);

      // bubble when IF has nothing
      valid_i = 1'b0;
      tick();
      $display("bubble");
      chk("bubble_valid", valid_id_o, 0);
      chk("bubble_class", op_class_o, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage directly downstream of the IF stage. It holds the IF/ID pipeline register, decodes RV32I instructions, and contains the 32x32 integer register file with its writeback port. It also merges IF traps with decode traps (illegal instruction, ECALL, EBREAK), feeds the EX stage, and returns a ready signal that drives the IF PC_en.

Parameters:
NOP_INSTR, 32'h0000_0013, instruction value held in the pipeline register after reset or flush (addi x0,x0,0).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
instr_i  in  32  fetched instruction from IF
PC_i  in  32  PC of instr_i
PC4_i  in  32  PC+4 of instr_i
is_trap_i  in  1  IF trap flag
trap_code_i  in  4  IF trap code
valid_i  in  1  IF holds a completed fetch (inverse of IF stall)
stall_i  in  1  downstream hold; freezes the ID register
flush_i  in  1  kill the instruction in ID (jump/branch/trap redirect)
wb_we_i  in  1  register-file write enable
wb_rd_i  in  5  write address
wb_data_i  in  32  write data
ready_o  out  1  ID accepts a new instruction this cycle; drives IF PC_en
valid_id_o  out  1  ID holds a live instruction
PC_id_o  out  32  latched PC
PC4_id_o  out  32  latched PC+4
rs1_o, rs2_o, rd_o  out  5 each  register indices (instr[19:15], [24:20], [11:7])
rs1_data_o, rs2_data_o  out  32 each  operand values
imm_o  out  32  sign-extended immediate
funct3_o  out  3  instr[14:12]
funct7b5_o  out  1  instr[30]
op_class_o  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 illegal
is_trap_id_o  out  1  trap flag
trap_code_id_o  out  4  trap code

Behaviour:
- Reset (rst_ni low, asynchronous): valid 0, instr register = NOP_INSTR, PC/PC4 registers 0, trap registers 0, all 31 writable registers 0. Consequently is_trap_id_o is 0 and op_class_o is 7.
- ready_o = ~stall_i (combinational).
- Register update at posedge, in priority order:
  - flush_i: valid <= 0, instr <= NOP_INSTR, trap <= 0. Flush overrides stall_i.
  - stall_i: all registers hold.
  - Otherwise: valid <= valid_i, and instr, PC, PC4 and trap fields are captured from the inputs.
  - When valid_i is 0, the capture loads NOP_INSTR and trap 0, so a bubble is inserted.
- Decode is combinational from the latched instruction, so latency from IF is 1 cycle.
- Immediates:
  - I-type: {{20{i[31]}}, i[31:20]}
  - S-type: {{20{i[31]}}, i[31:25], i[11:7]}
  - B-type: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
  - U-type: {i[31:12], 12'b0}
  - J-type: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
  - Otherwise 0.
- Illegal instruction (op_class 15) when any of:
  - i[1:0] != 2'b11, or the opcode is unlisted.
  - JALR with funct3 != 0.
  - BRANCH with funct3 of 2 or 3.
  - LOAD with funct3 of 3, 6 or 7.
  - STORE with funct3 > 2.
  - OP with funct7 not in {0, 0x20}, or funct7 = 0x20 with funct3 not in {0, 5}.
  - OP-IMM: SLLI with funct7 != 0, or SRLI/SRAI with funct7 not in {0, 0x20}.
  - SYSTEM with funct3 = 0 and i[31:7] not equal to ECALL or EBREAK. Other SYSTEM funct3 values pass through as class 10.
- Trap priority:
  - Latched IF trap: pass its code unchanged.
  - Else illegal: code 2.
  - Else ECALL (32'h0000_0073): code 11.
  - Else EBREAK (32'h0010_0073): code 3.
  - is_trap_id_o is forced to 0 when valid_id_o is 0.
- Register file:
  - Write at posedge when wb_we_i is high and wb_rd_i != 0. x0 always reads 0.
  - Reads are combinational with write-through bypass: if wb_we_i is high, wb_rd_i == rsN and rsN != 0, rsN_data_o = wb_data_i.
  - Writes occur regardless of stall_i and flush_i.

Test Plan:
- Reset, then release with valid_i=1, instr_i=32'h00500093 (addi x1,x0,5), PC_i=0x100 -> next cycle: valid_id_o=1, op_class_o=7, imm_o=5, rd_o=1, PC_id_o=0x100, PC4_id_o=0x104.
- wb_we_i=1, wb_rd_i=3, wb_data_i=0xDEADBEEF in the same cycle ID decodes rs1=3 -> rs1_data_o=0xDEADBEEF combinationally. Next cycle with wb_we_i=0, the read still returns 0xDEADBEEF. A write to x0 leaves reads of x0 at 0.
- Hold stall_i=1 for 3 cycles while instr_i changes -> outputs frozen and ready_o=0. Assert flush_i together with stall_i -> valid_id_o=0 next cycle.
- instr_i=32'hFFFFFFFF -> op_class_o=15, is_trap_id_o=1, trap_code_id_o=2. Repeat with is_trap_i=1, trap_code_i=1 -> trap_code_id_o=1 (IF trap wins).
- ECALL 32'h00000073 -> trap code 11. EBREAK 32'h00100073 -> trap code 3. Branch 32'hFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFFFFFC, op_class_o=4.
- Pulse rst_ni low mid-stream asynchronously, between clock edges -> valid_id_o drops immediately, and x1 reads 0 after release.
